// File: rtl/fft_peak_detector.sv
// Finds the largest |X|^2 bin in the positive-frequency half of each streamed FFT frame.
// The result is published one cycle after the last bin of the frame is accepted.
//
// state  | meaning
// IDLE   | waiting for bin 0 of a frame
// ACCUM  | frame partially received
// REPORT | frame result published this cycle
module fft_peak_detector #(
    parameter int FFT_SIZE = 256,
    parameter int DATA_W   = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fft_valid_i,
    input  logic [DATA_W-1:0]           fft_real_i,
    input  logic [DATA_W-1:0]           fft_imag_i,
    input  logic [2*DATA_W-1:0]         thresh_i,
    output logic                        peak_valid_o,
    output logic [$clog2(FFT_SIZE)-2:0] peak_bin_o,
    output logic [2*DATA_W-1:0]         peak_mag_sq_o,
    output logic                        peak_detect_o,
    output logic                        busy_o
);
    localparam int CNT_W = $clog2(FFT_SIZE);
    localparam int IDX_W = CNT_W - 1;
    localparam int SQ_W  = 2*DATA_W - 1;
    localparam int MAG_W = 2*DATA_W;

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_bin;

    logic [SQ_W-1:0]    re_ext, im_ext, re_prod, im_prod;
    logic               s1_valid_q, s2_valid_q;
    logic [IDX_W-1:0]   s1_bin_q, s2_bin_q;
    logic [SQ_W-1:0]    re_sq_q, im_sq_q;
    logic [MAG_W-1:0]   mag_d, mag_q;
    logic [MAG_W-1:0]   max_mag_q;
    logic [IDX_W-1:0]   max_bin_q;

    logic               peak_valid_q, peak_detect_q;
    logic [IDX_W-1:0]   peak_bin_q;
    logic [MAG_W-1:0]   peak_mag_q;

    // A square is never negative and at most 2^(2*DATA_W-2), so the low
    // 2*DATA_W-1 bits of the sign-extended product hold it exactly as unsigned.
    assign re_ext  = {{(DATA_W-1){fft_real_i[DATA_W-1]}}, fft_real_i};
    assign im_ext  = {{(DATA_W-1){fft_imag_i[DATA_W-1]}}, fft_imag_i};
    assign re_prod = re_ext * re_ext;
    assign im_prod = im_ext * im_ext;
    assign mag_d   = {1'b0, re_sq_q} + {1'b0, im_sq_q};

    assign last_bin = &cnt_q;

    // Only the lower half of the frame enters the compare pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s2_bin_q   <= '0;
            re_sq_q    <= '0;
            im_sq_q    <= '0;
            mag_q      <= '0;
            max_mag_q  <= '0;
            max_bin_q  <= '0;
        end else begin
            s1_valid_q <= fft_valid_i & ~cnt_q[CNT_W-1];
            s1_bin_q   <= cnt_q[IDX_W-1:0];
            re_sq_q    <= re_prod;
            im_sq_q    <= im_prod;
            s2_valid_q <= s1_valid_q;
            s2_bin_q   <= s1_bin_q;
            mag_q      <= mag_d;
            if (s2_valid_q && ((s2_bin_q == '0) || (mag_q > max_mag_q))) begin
                max_mag_q <= mag_q;
                max_bin_q <= s2_bin_q;
            end
        end
    end

    // The running max is settled well before bin FFT_SIZE-1 arrives, since the
    // upper half of the frame takes at least FFT_SIZE/2 cycles to stream in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            peak_valid_q  <= 1'b0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            peak_detect_q <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (fft_valid_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (fft_valid_i) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (fft_valid_i && last_bin) begin
                        state_q       <= REPORT;
                        peak_valid_q  <= 1'b1;
                        peak_bin_q    <= max_bin_q;
                        peak_mag_q    <= max_mag_q;
                        peak_detect_q <= (max_mag_q > thresh_i);
                    end
                end
                REPORT: begin
                    state_q <= fft_valid_i ? ACCUM : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign peak_valid_o  = peak_valid_q;
    assign peak_bin_o    = peak_bin_q;
    assign peak_mag_sq_o = peak_mag_q;
    assign peak_detect_o = peak_detect_q;
    assign busy_o        = (state_q == ACCUM);

endmodule
